// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: widths, instruction
// field positions, halt opcode and the sequencer state type.
package fetch_sequencer_pkg;

    localparam int WORD_W    = 20;
    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;

    // Instruction field positions
    localparam int OP_LSB    = 0;
    localparam int OP_MSB    = 4;
    localparam int ADDRA_LSB = 5;
    localparam int ADDRA_MSB = 9;
    localparam int ADDRB_LSB = 10;
    localparam int ADDRB_MSB = 14;
    localparam int ADDRW_LSB = 15;
    localparam int ADDRW_MSB = 19;

    localparam logic [OP_MSB-OP_LSB:0] HALT_OP  = 5'd31;
    localparam logic [WORD_W-1:0]      RESET_PC = 20'd0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Opcode field of an instruction word
    function automatic logic [OP_MSB-OP_LSB:0] opcode_of(
        input logic [WORD_W-1:0] word
    );
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter register: selects reset value, redirect target,
// increment or hold for the next cycle.
module pc_register
    import fetch_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
    input  logic              redirect_valid_i,
    input  logic [WORD_W-1:0] redirect_pc_i,
    output logic [WORD_W-1:0] pc_o
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // Next PC: redirect beats advance; increment wraps naturally at 2^20
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + WORD_W'(1);
        end
    end

    // PC state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads instruction memory and hands one
// registered instruction per valid/ready transfer to decode.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MEM_DEPTH-1:0][WORD_W-1:0] mem,
    input  logic                             redirect_valid,
    input  logic [WORD_W-1:0]                redirect_pc,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [WORD_W-1:0]                out_instr,
    output logic [WORD_W-1:0]                out_pc,
    output logic                             halted,
    output logic [WORD_W-1:0]                fetch_count
);

    state_e            state_q;
    logic              out_valid_q;
    logic [WORD_W-1:0] out_instr_q;
    logic [WORD_W-1:0] out_pc_q;
    logic              halted_q;
    logic [WORD_W-1:0] count_q;
    logic [WORD_W-1:0] count_d;

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] fetch_word;
    logic              transfer;
    logic              slot_free;
    logic              fetch_en;
    logic              is_halt;

    // Advance/redirect selection lives in the PC register
    pc_register u_pc (
        .clk              (clk),
        .rst              (rst),
        .advance_i        (fetch_en),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_o             (pc)
    );

    // Memory read, handshake decode and fetch decision
    always_comb begin
        fetch_word = mem[pc[ADDR_W-1:0]];
        transfer   = out_valid_q && out_ready;
        slot_free  = !out_valid_q || out_ready;
        fetch_en   = (state_q == RUN) && !redirect_valid && slot_free;
        is_halt    = opcode_of(fetch_word) == HALT_OP;
        count_d    = count_q;
        if (transfer && !redirect_valid) begin
            count_d = count_q + WORD_W'(1);
        end
    end

    // RUN/HALT FSM with registered output slot and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
            count_q     <= '0;
        end else if (redirect_valid) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (fetch_en) begin
                out_valid_q <= 1'b1;
                out_instr_q <= fetch_word;
                out_pc_q    <= pc;
                if (is_halt) begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end
            end else if (transfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: cycle-by-cycle vector table
// plus a hand-written halt/idle sequence, checked through a queue.
module tb_fetch_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0][19:0] mem;
    logic              redirect_valid;
    logic [19:0]       redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [19:0]       out_instr;
    logic [19:0]       out_pc;
    logic              halted;
    logic [19:0]       fetch_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [19:0] rpc;
        logic        rdy;
        logic        v;
        logic [19:0] pc;
        logic [19:0] instr;
        logic        h;
        logic [19:0] cnt;
    } vec_t;

    vec_t vecs[28];
    vec_t sb[$];

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .mem            (mem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic r, input logic rv, input logic [19:0] rpc,
        input logic rdy, input logic v, input logic [19:0] pc,
        input logic [19:0] ins, input logic h, input logic [19:0] c
    );
        vec_t t;
        t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.v = v; t.pc = pc; t.instr = ins; t.h = h; t.cnt = c;
        return t;
    endfunction

    task automatic cmp(input string nm, input int step,
                       input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h",
                     nm, step, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, check after the edge
    task automatic step(input int n, input vec_t t);
        vec_t e;
        @(negedge clk);
        rst            = t.rst;
        redirect_valid = t.rv;
        redirect_pc    = t.rpc;
        out_ready      = t.rdy;
        sb.push_back(t);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp("out_valid", n, 20'(out_valid), 20'(e.v));
        cmp("halted", n, 20'(halted), 20'(e.h));
        cmp("fetch_count", n, fetch_count, e.cnt);
        if (e.v || e.rst) begin
            cmp("out_pc", n, out_pc, e.pc);
            cmp("out_instr", n, out_instr, e.instr);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 20'h100 + 20'(k);
        mem[4]  = 20'h001FF;
        mem[31] = 20'hABC00;
        rst = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;

        //           rst rv rpc       rdy v  pc        instr     h  cnt
        vecs[0]  = mk(1, 0, 20'h0,     1, 0, 20'h0,     20'h0,    0, 0);
        vecs[1]  = mk(0, 0, 20'h0,     1, 1, 20'h0,     20'h100,  0, 0);
        vecs[2]  = mk(0, 0, 20'h0,     1, 1, 20'h1,     20'h101,  0, 1);
        vecs[3]  = mk(0, 0, 20'h0,     1, 1, 20'h2,     20'h102,  0, 2);
        vecs[4]  = mk(0, 0, 20'h0,     0, 1, 20'h2,     20'h102,  0, 2);
        vecs[5]  = mk(0, 0, 20'h0,     0, 1, 20'h2,     20'h102,  0, 2);
        vecs[6]  = mk(0, 0, 20'h0,     0, 1, 20'h2,     20'h102,  0, 2);
        vecs[7]  = mk(0, 0, 20'h0,     1, 1, 20'h3,     20'h103,  0, 3);
        vecs[8]  = mk(0, 0, 20'h0,     1, 1, 20'h4,     20'h1FF,  1, 4);
        vecs[9]  = mk(0, 0, 20'h0,     0, 1, 20'h4,     20'h1FF,  1, 4);
        vecs[10] = mk(0, 0, 20'h0,     1, 0, 20'h4,     20'h1FF,  1, 5);
        vecs[11] = mk(0, 0, 20'h0,     1, 0, 20'h4,     20'h1FF,  1, 5);
        vecs[12] = mk(0, 0, 20'h0,     1, 0, 20'h4,     20'h1FF,  1, 5);
        vecs[13] = mk(0, 1, 20'h9,     1, 0, 20'h0,     20'h0,    0, 5);
        vecs[14] = mk(0, 0, 20'h0,     1, 1, 20'h9,     20'h109,  0, 5);
        vecs[15] = mk(0, 1, 20'hFFFFE, 1, 0, 20'h0,     20'h0,    0, 5);
        vecs[16] = mk(0, 0, 20'h0,     1, 1, 20'hFFFFE, 20'h11E,  0, 5);
        vecs[17] = mk(0, 0, 20'h0,     1, 1, 20'hFFFFF, 20'hABC00,0, 6);
        vecs[18] = mk(0, 0, 20'h0,     1, 1, 20'h0,     20'h100,  0, 7);
        vecs[19] = mk(0, 0, 20'h0,     0, 1, 20'h0,     20'h100,  0, 7);
        vecs[20] = mk(1, 0, 20'h0,     0, 0, 20'h0,     20'h0,    0, 0);
        vecs[21] = mk(0, 0, 20'h0,     1, 1, 20'h0,     20'h100,  0, 0);
        vecs[22] = mk(0, 1, 20'h9,     0, 0, 20'h0,     20'h0,    0, 0);
        vecs[23] = mk(0, 0, 20'h0,     1, 1, 20'h9,     20'h109,  0, 0);
        vecs[24] = mk(0, 1, 20'h4,     0, 0, 20'h0,     20'h0,    0, 0);
        vecs[25] = mk(0, 0, 20'h0,     0, 1, 20'h4,     20'h1FF,  1, 0);
        vecs[26] = mk(1, 0, 20'h0,     0, 0, 20'h0,     20'h0,    0, 0);
        vecs[27] = mk(0, 0, 20'h0,     1, 1, 20'h0,     20'h100,  0, 0);

        for (int i = 0; i < 28; i++) step(i, vecs[i]);

        // Redirect with ready high drops the word, then halt and idle
        step(100, mk(0, 1, 20'h4, 1, 0, 20'h0, 20'h0,   0, 0));
        step(101, mk(0, 0, 20'h0, 1, 1, 20'h4, 20'h1FF, 1, 0));
        step(102, mk(0, 0, 20'h0, 1, 0, 20'h0, 20'h0,   1, 1));
        for (int i = 0; i < 10; i++)
            step(103 + i, mk(0, 0, 20'h0, 1, 0, 20'h0, 20'h0, 1, 1));
        step(120, mk(0, 1, 20'h1F, 0, 0, 20'h0, 20'h0,     0, 1));
        step(121, mk(0, 0, 20'h0,  0, 1, 20'h1F, 20'hABC00, 0, 1));
        step(122, mk(0, 0, 20'h0,  1, 1, 20'h20, 20'h100,   0, 2));

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d left expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
